// File: rtl/shreg_serializer_ctrl.sv
// shreg_serializer_ctrl
//   Parallel-in / serial-out sequencer built on a WIDTH-cell load/shift chain.
//   Words are accepted through a valid/ready handshake, parallel-loaded into
//   the chain, and shifted out LSB-first, one bit per cycle unless paused.
//
// Handshake: a word transfers on a rising edge where start_valid and
//   start_ready are both high. The producer must hold data_in stable while
//   start_valid is high and start_ready is low. start_ready is not a function
//   of start_valid, so there is no combinational loop through the handshake.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   reset        asynchronous, active-high clear of all state
//   start_valid  producer offers data_in
//   start_ready  block will accept data_in on this edge
//   data_in      parallel word to load
//   fill_bit     value shifted into the top cell
//   pause        consumer stall, freezes the chain and the bit counter
//   serial_out   current serial bit (cell 0)
//   bit_valid    serial_out carries a data bit
//   bit_last     serial_out is bit WIDTH-1 of the word
//   done         one-cycle pulse after the last bit is consumed
//   busy         word in flight
//   chain_q      all cell outputs
module shreg_serializer_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] data_in,
  input  logic             fill_bit,
  input  logic             pause,
  output logic             serial_out,
  output logic             bit_valid,
  output logic             bit_last,
  output logic             done,
  output logic             busy,
  output logic [WIDTH-1:0] chain_q
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] shift_in;
  logic [WIDTH-1:0] q_next;
  logic             done_r;

  logic             in_shift;
  logic             is_last;
  logic             accept;
  logic             load_en;
  logic             shift_en;

  assign in_shift = (state == SHIFT);
  assign is_last  = in_shift && (cnt == CW'(WIDTH - 1));

  // Ready in IDLE, or on the last bit when it is actually being consumed,
  // which lets the next word load on the same edge (gapless streaming).
  // Held low while reset is asserted.
  assign start_ready = ~reset & (~in_shift | (is_last & ~pause));
  assign accept      = start_valid & start_ready;
  assign load_en     = accept;
  assign shift_en    = in_shift & ~pause;

  // Per-cell mux: load overrides shift, shift overrides hold.
  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_cell
      if (i == WIDTH - 1) begin : g_top
        assign shift_in[i] = fill_bit;
      end else begin : g_mid
        assign shift_in[i] = q[i+1];
      end
      assign q_next[i] = load_en  ? data_in[i] :
                         shift_en ? shift_in[i] : q[i];
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else begin
      q <= q_next;
    end
  end

  // Sequencer FSM. The chain itself is steered by load_en/shift_en above;
  // this block tracks which bit is on serial_out and issues done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (!pause) begin
            if (is_last) begin
              done_r <= 1'b1;
              cnt    <= '0;
              // Without a new word the chain still takes its final shift.
              if (!accept) begin
                state <= IDLE;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign serial_out = q[0];
  assign chain_q    = q;
  assign bit_valid  = in_shift;
  assign busy       = in_shift;
  assign bit_last   = is_last;
  assign done       = done_r;

endmodule

// File: tb/tb_shreg_serializer_ctrl.sv
// Directed bench for shreg_serializer_ctrl (WIDTH = 8).
// Inputs are driven and outputs checked at the falling edge, midway between
// the rising edges where the DUT updates.
module tb_shreg_serializer_ctrl;

  logic       clk;
  logic       reset;
  logic       start_valid;
  logic       start_ready;
  logic [7:0] data_in;
  logic       fill_bit;
  logic       pause;
  logic       serial_out;
  logic       bit_valid;
  logic       bit_last;
  logic       done;
  logic       busy;
  logic [7:0] chain_q;

  int total_checks = 0;
  int passed_checks = 0;

  shreg_serializer_ctrl #(.WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .start_valid(start_valid),
    .start_ready(start_ready),
    .data_in    (data_in),
    .fill_bit   (fill_bit),
    .pause      (pause),
    .serial_out (serial_out),
    .bit_valid  (bit_valid),
    .bit_last   (bit_last),
    .done       (done),
    .busy       (busy),
    .chain_q    (chain_q)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_checks++;
    assert (obs === exp) passed_checks++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, " serial_out"}, {31'd0, serial_out}, 32'd0);
    chk({tag, " bit_valid"},  {31'd0, bit_valid},  32'd0);
    chk({tag, " bit_last"},   {31'd0, bit_last},   32'd0);
    chk({tag, " done"},       {31'd0, done},       32'd0);
    chk({tag, " busy"},       {31'd0, busy},       32'd0);
    chk({tag, " chain_q"},    {24'd0, chain_q},    32'd0);
  endtask

  // Offer a word at a falling edge; after the next falling edge the accept
  // edge has passed and bit 0 should be visible. hold_valid keeps start_valid
  // high for a following back-to-back word.
  task automatic begin_word(input logic [7:0] w, input logic hold_valid);
    data_in     = w;
    start_valid = 1'b1;
    chk($sformatf("ready_before_%h", w), {31'd0, start_ready}, 32'd1);
    @(negedge clk);
    if (!hold_valid) start_valid = 1'b0;
  endtask

  // Observe a whole word. exp_bits lists the expected serial bits, bit i of
  // exp_bits being the bit expected in the i-th serial slot. Bit pidx is
  // held for plen extra cycles by pause.
  task automatic shift_word(input string name, input logic [7:0] exp_bits,
                            input int pidx, input int plen, input logic done_first);
    int reps;
    for (int i = 0; i < 8; i++) begin
      reps = (i == pidx) ? plen + 1 : 1;
      for (int r = 0; r < reps; r++) begin
        chk($sformatf("%s bit%0d.%0d serial_out", name, i, r), {31'd0, serial_out}, {31'd0, exp_bits[i]});
        chk($sformatf("%s bit%0d.%0d bit_valid", name, i, r), {31'd0, bit_valid}, 32'd1);
        chk($sformatf("%s bit%0d.%0d busy", name, i, r), {31'd0, busy}, 32'd1);
        chk($sformatf("%s bit%0d.%0d bit_last", name, i, r), {31'd0, bit_last}, (i == 7) ? 32'd1 : 32'd0);
        chk($sformatf("%s bit%0d.%0d done", name, i, r), {31'd0, done},
            (i == 0 && r == 0 && done_first) ? 32'd1 : 32'd0);
        chk($sformatf("%s bit%0d.%0d start_ready", name, i, r), {31'd0, start_ready},
            (i == 7 && pause == 1'b0) ? 32'd1 : 32'd0);
        pause = (i == pidx && r < plen) ? 1'b1 : 1'b0;
        @(negedge clk);
      end
    end
  endtask

  // Word finished with no follow-on word.
  task automatic end_check(input string name);
    chk({name, " end done"},        {31'd0, done},        32'd1);
    chk({name, " end busy"},        {31'd0, busy},        32'd0);
    chk({name, " end bit_valid"},   {31'd0, bit_valid},   32'd0);
    chk({name, " end start_ready"}, {31'd0, start_ready}, 32'd1);
    @(negedge clk);
    chk({name, " done cleared"},    {31'd0, done},        32'd0);
  endtask

  // Directed stimulus
  initial begin
    reset       = 1'b1;
    start_valid = 1'b0;
    data_in     = 8'h00;
    fill_bit    = 1'b0;
    pause       = 1'b0;

    #2;
    chk_idle_outputs("power_on_reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("start_ready after release", {31'd0, start_ready}, 32'd1);
    @(negedge clk);

    // Pause in IDLE has no effect
    pause = 1'b1;
    @(negedge clk);
    chk("idle pause start_ready", {31'd0, start_ready}, 32'd1);
    chk("idle pause busy", {31'd0, busy}, 32'd0);
    pause = 1'b0;

    // Single word A5: serial 1,0,1,0,0,1,0,1
    begin_word(8'hA5, 1'b0);
    shift_word("single_A5", 8'b1010_0101, -1, 0, 1'b0);
    end_check("single_A5");

    // Pause on bit 3 for 3 cycles
    begin_word(8'hA5, 1'b0);
    shift_word("pause_A5", 8'b1010_0101, 3, 3, 1'b0);
    end_check("pause_A5");

    // Pause on the last bit: ready stays low while paused
    begin_word(8'h5A, 1'b0);
    shift_word("lastpause_5A", 8'b0101_1010, 7, 2, 1'b0);
    end_check("lastpause_5A");

    // Back-to-back 01 then FF with start_valid held
    begin_word(8'h01, 1'b1);
    data_in = 8'hFF;
    shift_word("b2b_01", 8'b0000_0001, -1, 0, 1'b0);
    start_valid = 1'b0;
    shift_word("b2b_FF", 8'b1111_1111, -1, 0, 1'b1);
    end_check("b2b_FF");

    // Fill bit: 00 with fill_bit=1 leaves FF in the chain
    fill_bit = 1'b1;
    begin_word(8'h00, 1'b0);
    shift_word("fill_00", 8'b0000_0000, -1, 0, 1'b0);
    chk("fill chain_q", {24'd0, chain_q}, 32'h0000_00FF);
    end_check("fill_00");
    fill_bit = 1'b0;

    // Reset abort at cnt=4 on word C3 (bits 1,1,0,0,0,0,1,1)
    begin_word(8'hC3, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("abort bit%0d serial_out", i), {31'd0, serial_out}, (i < 2) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
    chk("abort cnt4 busy", {31'd0, busy}, 32'd1);
    chk("abort cnt4 chain_q", {24'd0, chain_q}, 32'h0000_000C);
    reset = 1'b1;
    #1;
    chk_idle_outputs("async_reset_midword");
    @(negedge clk);
    chk("abort no done", {31'd0, done}, 32'd0);
    reset = 1'b0;
    #1;
    chk("abort start_ready after release", {31'd0, start_ready}, 32'd1);
    @(negedge clk);
    chk("abort no late done", {31'd0, done}, 32'd0);

    // Next word 3C serializes cleanly: 0,0,1,1,1,1,0,0
    begin_word(8'h3C, 1'b0);
    shift_word("after_abort_3C", 8'b0011_1100, -1, 0, 1'b0);
    end_check("after_abort_3C");

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule

// File: doc/shreg_serializer_ctrl.md
# shreg_serializer_ctrl

Sequencer for a chain of load/shift register cells. Each cell is a mux-DFF: load overrides shift, and shift overrides hold. The block instantiates a WIDTH-cell chain and accepts parallel words through a valid/ready handshake. It parallel-loads each accepted word and then shifts it out LSB-first, one bit per enabled cycle. It sits between a word-oriented producer and a serial-bit consumer that can stall the stream.

## Interface
Parameters:
- WIDTH, 8, number of register cells and bits per word (WIDTH ≥ 2)
- CW, $clog2(WIDTH), bit-counter width (derived, not overridden)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- start_valid  in  1  producer has a word on data_in
- start_ready  out  1  block accepts data_in this cycle
- data_in  in  WIDTH  parallel word loaded into the chain on handshake
- fill_bit  in  1  shift-in value for cell WIDTH-1
- pause  in  1  consumer stall; suppresses shifting while high
- serial_out  out  1  Q of cell 0 (current bit)
- bit_valid  out  1  serial_out carries a valid data bit
- bit_last  out  1  current bit is bit WIDTH-1 of the word
- done  out  1  one-cycle pulse after the last bit of a word is consumed
- busy  out  1  high while in SHIFT
- chain_q  out  WIDTH  all cell outputs, for observation

## Operation
- Chain structure:
  - Cell i receives shift input Q[i+1]; cell WIDTH-1 receives fill_bit.
  - Each cell's load value is data_in[i].
  - Per cell, next Q = L ? data_in[i] : (E ? shift_in : Q).
- States:
  - IDLE: start_ready=1, E=0.
  - SHIFT: holds a word being serialized.
- Internal counter cnt, CW bits, indexes the bit currently on serial_out.
- Handshake: accept = start_valid & start_ready. L = accept, decoded combinationally and applied to all cells.
- IDLE:
  - accept → chain loads data_in, cnt←0, go to SHIFT.
  - No accept → chain holds.
- SHIFT:
  - bit_valid=1, busy=1, bit_last = (cnt==WIDTH-1).
  - E = ~pause.
  - Not last and !pause: chain shifts, cnt←cnt+1.
  - pause: chain and cnt hold; no state change.
  - Last and !pause: the bit is consumed and done is registered high for the next cycle. Then:
    - If accept: load the new word, cnt←0, stay in SHIFT.
    - Otherwise: go to IDLE; the chain performs the final shift.
- start_ready = IDLE | (SHIFT & bit_last & ~pause). This gives gapless back-to-back words.
- Simultaneous load and shift: L has priority, so the new word replaces the shift.
- start_valid in SHIFT with start_ready low: ignored. The producer must hold data_in until accepted.
- cnt never exceeds WIDTH-1.

## Timing
- Reset values:
  - state=IDLE, cnt=0, chain_q=0.
  - serial_out=0, done=0, busy=0, bit_valid=0, bit_last=0.
  - start_ready=1 once reset is deasserted.
- Load latency: bit 0 appears on serial_out in the cycle immediately after the accept edge.
- Unpaused throughput: one bit per cycle. A word occupies exactly WIDTH cycles in SHIFT, plus any paused cycles.
- done is high exactly one cycle, in the cycle after the last bit's consuming edge. It coincides with bit 0 of the next word when words run back-to-back.
- After a word ends without a new accept, chain_q holds the shifted residue, which includes fill bits. Its value is not meaningful.
- Reset mid-word: the chain and FSM clear asynchronously, no done pulse is issued, and the word is discarded.
- pause in IDLE: no effect.
- pause on the last bit: start_ready stays low until pause drops.

## Test plan
- Reset check: assert reset mid-simulation → all outputs at reset values asynchronously, before the next clock edge; start_ready=1 after release.
- Single word: data_in=8'hA5, pause=0 → serial_out 1,0,1,0,0,1,0,1 over 8 consecutive cycles, with bit_last only on the 8th cycle, done high on the 9th cycle, and busy low on the 9th cycle.
- Pause: 8'hA5 with pause high for 3 cycles during bit 3 → bit 3 is held for 4 cycles; the remaining bits are unchanged; done arrives 3 cycles later than in the single-word case.
- Back-to-back: 8'h01 then 8'hFF with start_valid held → 16 contiguous valid bits 1,0,0,0,0,0,0,0,1,1,1,1,1,1,1,1 and no gap; done pulses on the cycle of the second word's bit 0 and again after its bit 7.
- Fill bit: fill_bit=1, 8'h00 → chain_q after the final shift equals 8'hFF.
- Reset abort: reset asserted at cnt=4 → no done pulse, chain_q=0, next word 8'h3C serializes correctly.
